// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// FSM encodings and counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell.
// Computes x - y - bin.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first.
// One full-subtractor cell plus a borrow flop.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             bff;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] dmsb;
  logic [WIDTH-1:0] diff_nxt;

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (bff),
    .d    (d),
    .bout (bout)
  );

  // New bit enters at the MSB; WIDTH=1 safe.
  always_comb begin
    dmsb            = '0;
    dmsb[WIDTH-1]   = d;
    diff_nxt        = (diff >> 1) | dmsb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      bff    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            bff   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          diff <= diff_nxt;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bff  <= bout;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            borrow <= bout;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances
// checked each cycle against a cycle-count/arithmetic model.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sv [2];
  logic [31:0] av [2];
  logic [31:0] bv [2];
  logic        bz [2];
  logic        dn [2];
  logic        bo [2];
  logic [31:0] df [2];

  logic [7:0]  diff8;
  logic [0:0]  diff1;
  logic        busy8, done8, bor8;
  logic        busy1, done1, bor1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  int          k  [2];
  logic [31:0] ma [2];
  logic [31:0] mb [2];
  logic [31:0] ed [2];
  logic        eb [2];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (sv[0]),
    .a      (av[0][7:0]),
    .b      (bv[0][7:0]),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (bor8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (sv[1]),
    .a      (av[1][0:0]),
    .b      (bv[1][0:0]),
    .busy   (busy1),
    .done   (done1),
    .diff   (diff1),
    .borrow (bor1)
  );

  assign bz[0] = busy8;
  assign bz[1] = busy1;
  assign dn[0] = done8;
  assign dn[1] = done1;
  assign bo[0] = bor8;
  assign bo[1] = bor1;
  assign df[0] = {24'd0, diff8};
  assign df[1] = {31'd0, diff1};

  function automatic int wd(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  function automatic logic [31:0] msk(input int i);
    return (32'd1 << wd(i)) - 32'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: k = edges since accept (-1 idle); done after edge W.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        k[i]  = -1;
        ed[i] = '0;
        eb[i] = 1'b0;
      end else if (k[i] < 0) begin
        if (sv[i]) begin
          ma[i] = av[i] & msk(i);
          mb[i] = bv[i] & msk(i);
          k[i]  = 0;
        end
      end else if (k[i] == wd(i)) begin
        k[i] = -1;
      end else begin
        k[i]++;
        if (k[i] == wd(i)) begin
          ed[i] = (ma[i] - mb[i]) & msk(i);
          eb[i] = (ma[i] < mb[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), {31'd0, bz[i]}, {31'd0, k[i] >= 0});
        chk($sformatf("done%0d", i), {31'd0, dn[i]},
            {31'd0, k[i] == wd(i)});
        chk($sformatf("borrow%0d", i), {31'd0, bo[i]}, {31'd0, eb[i]});
        if (k[i] < 0 || k[i] == wd(i))
          chk($sformatf("diff%0d", i), df[i], ed[i]);
      end
    end
  end

  task automatic run_op(input int i, input logic [7:0] ta,
                        input logic [7:0] tb_, input logic [7:0] xd,
                        input logic xb, input bit hold);
    int n;
    bit seen;
    @(negedge clk);
    av[i] = {24'd0, ta};
    bv[i] = {24'd0, tb_};
    sv[i] = 1'b1;
    @(negedge clk);
    n = 1;
    if (hold) begin
      av[i] = 32'hFF;
      bv[i] = 32'hFF;
    end else begin
      sv[i] = 1'b0;
    end
    seen = 0;
    while (!seen && n < 40) begin
      if (dn[i]) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    sv[i] = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout%0d: got no done expected done", i);
    end else begin
      chk("lat", n, wd(i) + 1);
      chk("lit_diff", df[i], {24'd0, xd});
      chk("lit_borrow", {31'd0, bo[i]}, {31'd0, xb});
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0;
      av[i] = '0;
      bv[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_diff", df[0], 32'd0);
    rst_n = 1'b1;

    run_op(0, 8'h5A, 8'h21, 8'h39, 1'b0, 0);
    run_op(0, 8'h00, 8'h01, 8'hFF, 1'b1, 0);
    run_op(0, 8'hFF, 8'hFF, 8'h00, 1'b0, 0);
    run_op(0, 8'h10, 8'h01, 8'h0F, 1'b0, 1);
    repeat (3) @(negedge clk);

    // Abort mid-operation with reset at the third busy edge.
    @(negedge clk);
    av[0] = 32'h33;
    bv[0] = 32'h11;
    sv[0] = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_diff", df[0], 32'd0);
    chk("abort_borrow", {31'd0, bor8}, 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(0, 8'h80, 8'h7F, 8'h01, 1'b0, 0);

    run_op(1, 8'h0, 8'h0, 8'h0, 1'b0, 0);
    run_op(1, 8'h0, 8'h1, 8'h1, 1'b1, 0);
    run_op(1, 8'h1, 8'h0, 8'h1, 1'b0, 0);
    run_op(1, 8'h1, 8'h1, 8'h0, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(0, ra, rb, ra - rb, ra < rb, 0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
